// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Contents: bubble word and reset PC defaults, FSM state encodings,
// and a word-alignment helper used when misalignment checking is built in
// (macro IF_FETCH_MISALIGN_CHK_EN).
package if_fetch_pkg;

  localparam logic [31:0] IF_NOP_DEFAULT        = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] IF_RESET_ADDR_DEFAULT = 32'h0000_0000;

  localparam logic [1:0] IF_IDLE = 2'd0;
  localparam logic [1:0] IF_REQ  = 2'd1;
  localparam logic [1:0] IF_WAIT = 2'd2;
  localparam logic [1:0] IF_HOLD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = IF_IDLE,
    ST_REQ  = IF_REQ,
    ST_WAIT = IF_WAIT,
    ST_HOLD = IF_HOLD
  } if_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register for the fetch stage.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (pc <= RESET_ADDR)
//   load_en         load load_addr (redirect); wins over adv_en
//   load_addr       redirect target
//   adv_en          advance pc by 4 (request accepted), 32-bit wrap
//   pc              current fetch address
//   load_misaligned load_addr has nonzero low bits (IF_FETCH_MISALIGN_CHK_EN only)
// Macro IF_FETCH_MISALIGN_CHK_EN: redirect targets are forced word-aligned.
// Without it the target is loaded verbatim.
module if_pc_reg
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = IF_RESET_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic        adv_en,
  output logic [31:0] pc
`ifdef IF_FETCH_MISALIGN_CHK_EN
  ,
  output logic        load_misaligned
`endif
);

  logic [31:0] load_val;
  logic [31:0] pc_next;

`ifdef IF_FETCH_MISALIGN_CHK_EN
  assign load_val        = word_align(load_addr);
  assign load_misaligned = |load_addr[1:0];
`else
  assign load_val = load_addr;
`endif

  always_comb begin
    pc_next = pc;
    if (load_en)
      pc_next = load_val;
    else if (adv_en)
      pc_next = pc + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc <= RESET_ADDR;
    else
      pc <= pc_next;
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word
// requests (req/ready, then rvalid) and registers the result into the
// if_id boundary. Accepts stall (hold_i) and redirect (jump_en_i) from later
// stages; emits NOP bubbles when no valid instruction is available.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   jump_en_i, jump_addr_i    redirect request and target
//   hold_i                    freeze if_id outputs
//   mem_req_o, mem_addr_o     fetch request and word address (pc)
//   mem_ready_i               memory accepts the request this cycle
//   mem_rvalid_i, mem_rdata_i response for the accepted request
//   inst_o, inst_addr_o       instruction and its PC to decode
//   inst_valid_o              1 = real instruction, 0 = bubble
//   misalign_o                one-cycle pulse after a misaligned jump
//                             (only with IF_FETCH_MISALIGN_CHK_EN)
//
// state | meaning
// IDLE  | just out of reset, no request yet
// REQ   | request presented, waiting for mem_ready_i
// WAIT  | request accepted, waiting for mem_rvalid_i
// HOLD  | response parked in the buffer while decode stalls
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = IF_RESET_ADDR_DEFAULT,
  parameter logic [31:0] NOP_INST   = IF_NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
`ifdef IF_FETCH_MISALIGN_CHK_EN
  ,
  output logic        misalign_o
`endif
);

  if_state_t   state, state_next;
  logic        drop, drop_next;
  logic [31:0] pc;
  logic [31:0] fetch_addr;
  logic [31:0] buf_inst, buf_addr;
  logic        jump_act;
  logic        pc_adv;
  logic        dlv_wait;
  logic        dlv_buf;
  logic        buf_load;

  // Redirects are ignored in IDLE; elsewhere they override everything.
  assign jump_act = jump_en_i && (state != ST_IDLE);

  // pc has already advanced past the outstanding request.
  assign fetch_addr = pc - 32'd4;

`ifdef IF_FETCH_MISALIGN_CHK_EN
  logic pc_misaligned;
`endif

  if_pc_reg #(
    .RESET_ADDR(RESET_ADDR)
  ) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .load_en        (jump_act),
    .load_addr      (jump_addr_i),
    .adv_en         (pc_adv),
    .pc             (pc)
`ifdef IF_FETCH_MISALIGN_CHK_EN
    ,
    .load_misaligned(pc_misaligned)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      drop  <= 1'b0;
    end else begin
      state <= state_next;
      drop  <= drop_next;
    end
  end

  always_comb begin
    state_next = state;
    drop_next  = drop;
    pc_adv     = 1'b0;
    dlv_wait   = 1'b0;
    dlv_buf    = 1'b0;
    buf_load   = 1'b0;
    case (state)
      ST_IDLE: state_next = ST_REQ;
      ST_REQ: begin
        if (jump_act) begin
          // An accepted request now belongs to the old path: discard its response.
          if (mem_ready_i) begin
            state_next = ST_WAIT;
            drop_next  = 1'b1;
          end
        end else if (mem_ready_i) begin
          state_next = ST_WAIT;
          pc_adv     = 1'b1;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          drop_next  = 1'b0;
          state_next = ST_REQ;
          if (!jump_act && !drop) begin
            if (hold_i) begin
              buf_load   = 1'b1;
              state_next = ST_HOLD;
            end else begin
              dlv_wait = 1'b1;
            end
          end
        end else if (jump_act) begin
          drop_next = 1'b1;
        end
      end
      ST_HOLD: begin
        if (jump_act) begin
          state_next = ST_REQ;
        end else if (!hold_i) begin
          dlv_buf    = 1'b1;
          state_next = ST_REQ;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o  = (state == ST_REQ);
    mem_addr_o = pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_inst <= NOP_INST;
      buf_addr <= 32'd0;
    end else if (buf_load) begin
      buf_inst <= mem_rdata_i;
      buf_addr <= fetch_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_o       <= NOP_INST;
      inst_addr_o  <= 32'd0;
      inst_valid_o <= 1'b0;
    end else if (jump_act) begin
      inst_o       <= NOP_INST;
      inst_addr_o  <= 32'd0;
      inst_valid_o <= 1'b0;
    end else if (dlv_wait) begin
      inst_o       <= mem_rdata_i;
      inst_addr_o  <= fetch_addr;
      inst_valid_o <= 1'b1;
    end else if (dlv_buf) begin
      inst_o       <= buf_inst;
      inst_addr_o  <= buf_addr;
      inst_valid_o <= 1'b1;
    end else if (!hold_i) begin
      // Bubble: address of the last instruction is left as is.
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
    end
  end

`ifdef IF_FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      misalign_o <= 1'b0;
    else
      misalign_o <= jump_act && pc_misaligned;
  end
`endif

endmodule
